divider_64b: RTL and testbench

Multi-cycle 64-bit integer divider for the execute stage. It sits beside the 64-bit prefix adder, drives it as a subtractor once per cycle, and consumes its difference and carry-out. It implements restoring division for signed and unsigned operands, producing a quotient and remainder through valid/ready handshakes on both sides. The ALU issue logic feeds it, and the writeback mux consumes its output.

---
 rtl/gisa_alu_pkg.sv | 23 ++
 rtl/adder_64b.sv | 19 +
 rtl/divider_64b.sv | 168 ++++++++++++++++
 tb/tb_divider_64b.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gisa_alu_pkg.sv
// Shared ALU definitions: operand width, divider state encoding and 64-bit corner constants.
package gisa_alu_pkg;

  localparam int XLEN = 64;

  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    ITER = ST_ITER,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/adder_64b.sv
// 64-bit add/subtract (s=1 computes a-b via a+~b+1); purely combinational, no flow control.
// cout is the unsigned carry-out, i.e. a>=b when subtracting.
module adder_64b
  import gisa_alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            s,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  logic [XLEN:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {XLEN{s}}} + {{XLEN{1'b0}}, s};
  assign sum  = full[XLEN-1:0];
  assign cout = full[XLEN];

endmodule

// File: rtl/divider_64b.sv
// Restoring 64-bit signed/unsigned divider: 66 cycles from acceptance, 1 for divide-by-zero/overflow.
// One operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module divider_64b
  import gisa_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] div_abs_q, div_abs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            sgn_q, sgn_d;
  logic            fix_r_q, fix_r_d;

  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic [XLEN-1:0] add_a, add_b, add_sum;
  logic            add_s, add_cout, top, qbit;

  adder_64b u_adder (
    .a    (add_a),
    .b    (add_b),
    .s    (add_s),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Raw operands sit in q_q / div_abs_q between acceptance and PREP.
  always_comb begin
    dvd_neg = sgn_q & q_q[XLEN-1];
    dvs_neg = sgn_q & div_abs_q[XLEN-1];
    dvd_abs = dvd_neg ? -q_q : q_q;
    dvs_abs = dvs_neg ? -div_abs_q : div_abs_q;

    add_a = {r_q[XLEN-2:0], q_q[XLEN-1]};
    add_b = div_abs_q;
    add_s = 1'b1;
    top   = 1'b0;
    unique case (state_q)
      PREP: begin
        add_a = {{(XLEN-1){1'b0}}, dvd_abs[XLEN-1]};
        add_b = dvs_abs;
      end
      ITER: top = r_q[XLEN-1];
      FIX: begin
        add_a = '0;
        add_b = fix_r_q ? r_q : q_q;
      end
      default: ;
    endcase
    qbit = top | add_cout;
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    div_abs_d = div_abs_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sgn_d     = sgn_q;
    fix_r_d   = fix_r_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d       = dividend;
          div_abs_d = divisor;
          sgn_d     = in_signed;
          state_d   = PREP;
        end
      end
      PREP: begin
        fix_r_d = 1'b0;
        if (div_abs_q == '0) begin
          q_d     = ALL_ONES;
          r_d     = q_q;
          state_d = DONE;
        end else if (sgn_q && q_q == INT64_MIN && div_abs_q == ALL_ONES) begin
          r_d     = '0;
          state_d = DONE;
        end else begin
          // The first restoring step (R=0) is folded in here so 64 steps end at E64.
          q_neg_d   = dvd_neg ^ dvs_neg;
          r_neg_d   = dvd_neg;
          div_abs_d = dvs_abs;
          r_d       = qbit ? add_sum : add_a;
          q_d       = {dvd_abs[XLEN-2:0], qbit};
          cnt_d     = 6'd62;
          state_d   = ITER;
        end
      end
      ITER: begin
        r_d = qbit ? add_sum : add_a;
        q_d = {q_q[XLEN-2:0], qbit};
        if (cnt_q == 6'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      FIX: begin
        if (!fix_r_q) begin
          if (q_neg_q) q_d = add_sum;
          fix_r_d = 1'b1;
        end else begin
          if (r_neg_q) r_d = add_sum;
          fix_r_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      div_abs_q <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sgn_q     <= 1'b0;
      fix_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      div_abs_q <= div_abs_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      sgn_q     <= sgn_d;
      fix_r_q   <= fix_r_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: tb/tb_divider_64b.sv
// Self-checking bench for divider_64b: directed corner cases, randomized operands against a reference model.
module tb_divider_64b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [63:0] dividend = 64'd0;
  logic [63:0] divisor = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  divider_64b #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Reference: language-level division, truncating toward zero, plus the two special results.
  function automatic void ref_div(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output int lat);
    if (b == 64'd0) begin
      q = ONES; r = a; lat = 1;
    end else if (sgn && a == MIN64 && b == ONES) begin
      q = a; r = 64'd0; lat = 1;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      lat = 66;
    end else begin
      q = a / b;
      r = a % b;
      lat = 66;
    end
  endfunction

  // Issue one request, wait (bounded) for the result, then consume it.
  task automatic do_op(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r, output int lat,
                       output logic rdy_at_issue);
    @(negedge clk);
    in_valid = 1'b1; in_signed = sgn; dividend = a; divisor = b;
    rdy_at_issue = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    q = quotient;
    r = remainder;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 64'd0) begin n_err++; $display("FAIL reset_quotient got %h want 0", quotient); end
    n_cmp++; if (remainder !== 64'd0) begin n_err++; $display("FAIL reset_remainder got %h want 0", remainder); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t tv[7];
    logic [63:0] q, r;
    int lat;
    logic rdy;
    tv[0] = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66};
    tv[1] = '{1'b1, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 66};
    tv[2] = '{1'b1, 64'd7, -64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
    tv[3] = '{1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1};
    tv[4] = '{1'b1, MIN64, ONES, MIN64, 64'd0, 1};
    tv[5] = '{1'b0, ONES, 64'd1, ONES, 64'd0, 66};
    tv[6] = '{1'b1, -64'd5, 64'd0, ONES, -64'd5, 1};
    for (int i = 0; i < 7; i++) begin
      do_op(tv[i].sgn, tv[i].a, tv[i].b, q, r, lat, rdy);
      n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready got %b want 1", i, rdy); end
      n_cmp++; if (q !== tv[i].q) begin n_err++; $display("FAIL dir%0d_quotient got %h want %h", i, q, tv[i].q); end
      n_cmp++; if (r !== tv[i].r) begin n_err++; $display("FAIL dir%0d_remainder got %h want %h", i, r, tv[i].r); end
      n_cmp++; if (lat !== tv[i].lat) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tv[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, q, r, eq, er;
    logic sgn, rdy;
    int lat, elat, mode;
    for (int i = 0; i < 40; i++) begin
      sgn  = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      mode = $urandom_range(0, 6);
      case (mode)
        1: b = 64'($urandom_range(1, 20));
        2: b = 64'd0;
        3: b = ONES;
        4: a = MIN64;
        5: b = -64'($urandom_range(1, 1000));
        6: b = {32'd0, $urandom};
        default: ;
      endcase
      ref_div(sgn, a, b, eq, er, elat);
      do_op(sgn, a, b, q, r, lat, rdy);
      n_cmp++; if (q !== eq) begin n_err++; $display("FAIL rnd%0d_quotient s=%b a=%h b=%h got %h want %h", i, sgn, a, b, q, eq); end
      n_cmp++; if (r !== er) begin n_err++; $display("FAIL rnd%0d_remainder s=%b a=%h b=%h got %h want %h", i, sgn, a, b, r, er); end
      n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, elat); end
    end
  endtask

  task automatic test_hold_back_to_back();
    int lat, bad;
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; dividend = 64'd12345; divisor = 64'd10;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1 lat++; end
    n_cmp++; if (lat !== 66) begin n_err++; $display("FAIL hold_latency got %0d want 66", lat); end
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (quotient !== 64'd1234 || remainder !== 64'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; dividend = 64'd50; divisor = 64'd5;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_idle got rdy/vld %b want 10", {in_ready, out_valid}); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept got in_ready %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1 lat++; end
    n_cmp++; if (lat !== 66) begin n_err++; $display("FAIL b2b_latency got %0d want 66", lat); end
    n_cmp++; if (quotient !== 64'd10 || remainder !== 64'd0) begin n_err++; $display("FAIL b2b_result got %0d r %0d want 10 r 0", quotient, remainder); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    int seen, lat;
    logic [63:0] q, r;
    logic rdy;
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; dividend = 64'd1000; divisor = 64'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL flush_idle got rdy/vld %b want 10", {in_ready, out_valid}); end
    seen = 0;
    repeat (80) begin @(posedge clk); #1 if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_no_valid got %0d want 0", seen); end

    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b1; dividend = -64'd999; divisor = 64'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL rst_idle got rdy/vld %b want 10", {in_ready, out_valid}); end
    n_cmp++; if (quotient !== 64'd0 || remainder !== 64'd0) begin n_err++; $display("FAIL rst_outputs got %h %h want 0 0", quotient, remainder); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (80) begin @(posedge clk); #1 if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_no_valid got %0d want 0", seen); end

    do_op(1'b0, 64'd9, 64'd3, q, r, lat, rdy);
    n_cmp++; if (q !== 64'd3 || r !== 64'd0) begin n_err++; $display("FAIL after_abort_result got %0d r %0d want 3 r 0", q, r); end
    n_cmp++; if (lat !== 66) begin n_err++; $display("FAIL after_abort_latency got %0d want 66", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_back_to_back();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
